// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer writer: FSM states, default raster size
// and the luma weights used by the optional greyscale path.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2
    } fb_state_t;

    localparam int DEF_H_PIX  = 640;
    localparam int DEF_V_PIX  = 480;

    // Y = (5R + 9G + 2B) >> 4 tops out at 240, so an 8-bit sum never overflows
    localparam int LUMA_WR    = 5;
    localparam int LUMA_WG    = 9;
    localparam int LUMA_WB    = 2;
    localparam int LUMA_SHIFT = 4;

endpackage

// File: rtl/rgb444_to_luma.sv
// Combinational RGB444 -> 4-bit luma conversion used by the greyscale build of fb_writer.
module rgb444_to_luma
    import fb_pkg::*;
(
    input  logic [11:0] rgb,
    output logic [3:0]  y
);

    logic [7:0] sum;

    always_comb begin
        sum = 8'(LUMA_WR) * {4'b0, rgb[11:8]}
            + 8'(LUMA_WG) * {4'b0, rgb[7:4]}
            + 8'(LUMA_WB) * {4'b0, rgb[3:0]};
        y   = 4'(sum >> LUMA_SHIFT);
    end

endmodule

// File: rtl/fb_writer.sv
// Drains RGB444 words from the camera FIFO into a linear frame buffer, aligned to i_sof.
// Define FB_GREYSCALE_EN to store {Y,Y,Y} luma instead of the raw colour word.
module fb_writer
    import fb_pkg::*;
#(
    parameter int H_PIX  = DEF_H_PIX,
    parameter int V_PIX  = DEF_V_PIX,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_enable,
    input  logic              i_sof,
    input  logic              i_fifo_empty,
    input  logic [11:0]       i_fifo_data,
    output logic              o_fifo_rd,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [11:0]       o_mem_wdata,
    output logic              o_frame_done,
    output logic              o_err_short,
    output logic              o_busy
);

    localparam int                N_PIX     = H_PIX * V_PIX;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    fb_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              pipe_reg, pipe_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [11:0]       wdata_reg, wdata_next;
    logic              done_pend_reg, done_pend_next;
    logic              done_reg;
    logic              err_reg, err_next;
    logic              busy_reg;
    logic [11:0]       pix;

`ifdef FB_GREYSCALE_EN
    logic [3:0] luma;

    rgb444_to_luma u_luma (
        .rgb (i_fifo_data),
        .y   (luma)
    );

    assign pix = {luma, luma, luma};
`else
    assign pix = i_fifo_data;
`endif

    // Reads are issued whenever data is available outside IDLE; WAIT_SOF reads are flushes.
    assign o_fifo_rd = i_rstn && (state_reg != ST_IDLE) && !i_fifo_empty;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pipe_next      = 1'b0;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        done_pend_next = 1'b0;
        err_next       = 1'b0;

        if (!i_enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    if (i_sof) begin
                        state_next = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pipe_reg && (cnt_reg == LAST_ADDR)) begin
                        // Frame complete takes priority over a coincident sof; the
                        // read issued this cycle belongs to no frame and is dropped.
                        we_next        = 1'b1;
                        addr_next      = cnt_reg;
                        wdata_next     = pix;
                        done_pend_next = 1'b1;
                        cnt_next       = '0;
                        state_next     = i_sof ? ST_STREAM : ST_WAIT_SOF;
                    end else if (i_sof && (cnt_reg != '0)) begin
                        err_next  = 1'b1;
                        cnt_next  = '0;
                        pipe_next = o_fifo_rd;
                    end else begin
                        pipe_next = o_fifo_rd;
                        if (pipe_reg) begin
                            we_next    = 1'b1;
                            addr_next  = cnt_reg;
                            wdata_next = pix;
                            cnt_next   = cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pipe_reg      <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            done_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pipe_reg      <= pipe_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            done_pend_reg <= done_pend_next;
            done_reg      <= done_pend_reg;
            err_reg       <= err_next;
            busy_reg      <= (state_next == ST_STREAM);
        end
    end

    assign o_mem_we     = we_reg;
    assign o_mem_addr   = addr_reg;
    assign o_mem_wdata  = wdata_reg;
    assign o_frame_done = done_reg;
    assign o_err_short  = err_reg;
    assign o_busy       = busy_reg;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer on a reduced 16x8 raster, with a frame/epoch
// reference model, a queue-backed FIFO and randomized stalls, sof and enable drops.
module tb_fb_writer;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int N  = H * V;
    localparam int AW = 7;

`ifdef FB_GREYSCALE_EN
    localparam logic [11:0] LIT0 = 12'h444;
    localparam logic [11:0] LIT1 = 12'hFFF;
    localparam logic [11:0] LIT2 = 12'h888;
`else
    localparam logic [11:0] LIT0 = 12'hF00;
    localparam logic [11:0] LIT1 = 12'hFFF;
    localparam logic [11:0] LIT2 = 12'h0F0;
`endif

    logic          clk = 1'b0;
    logic          rstn, enable, sof, fifo_empty;
    logic [11:0]   fifo_data;
    logic          fifo_rd, mem_we, frame_done, err_short, busy;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata;

    always #5 clk = ~clk;

    fb_writer #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_enable     (enable),
        .i_sof        (sof),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd    (fifo_rd),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_frame_done (frame_done),
        .o_err_short  (err_short),
        .o_busy       (busy)
    );

    int checks = 0;
    int failures = 0;

    logic [11:0]   fq[$];
    bit            stall = 1'b0;
    bit            rnd_stall = 1'b0;
    bit            rd_taken = 1'b0;

    // Reference model: a frame epoch tags every read; anything that ends or aborts a
    // frame bumps the epoch so words still in flight no longer match and are dropped.
    bit            m_valid = 1'b0;
    bit            m_active = 1'b0;
    bit            m_in_frame = 1'b0;
    int            m_pos = 0;
    int            m_epoch = 0;
    int            m_pend_tag = -1;
    bit            m_done_flag = 1'b0;
    bit            e_we = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
    int            e_addr = 0;
    logic [11:0]   e_wdata = '0;

    int            n_we = 0, n_done = 0, n_err = 0, last_waddr = -1;
    logic [AW-1:0] wl_addr[$];
    logic [11:0]   wl_data[$];

    function automatic logic [11:0] expect_pixel(input logic [11:0] w);
`ifdef FB_GREYSCALE_EN
        int y;
        y = (5 * int'(w[11:8]) + 9 * int'(w[7:4]) + 2 * int'(w[3:0])) / 16;
        return {y[3:0], y[3:0], y[3:0]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        bit rdc;
        int arr_tag;
        bit word_ok;
        rdc = rstn && m_active && !fifo_empty;
        if (m_valid) begin
            chk("fifo_rd", fifo_rd, rdc);
            chk("mem_we", mem_we, e_we);
            if (e_we) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("frame_done", frame_done, e_done);
            chk("err_short", err_short, e_err);
            chk("busy", busy, e_busy);
            if (mem_we === 1'b1) begin
                n_we++;
                last_waddr = int'(mem_addr);
                wl_addr.push_back(mem_addr);
                wl_data.push_back(mem_wdata);
            end
            if (frame_done === 1'b1) begin
                n_done++;
                $display("txn frame_done #%0d t=%0t", n_done, $time);
            end
            if (err_short === 1'b1) begin
                n_err++;
                $display("txn err_short #%0d t=%0t", n_err, $time);
            end
        end
        rd_taken = fifo_rd;

        if (!rstn) begin
            m_active = 0; m_in_frame = 0; m_pos = 0; m_epoch++; m_pend_tag = -1;
            m_done_flag = 0; e_we = 0; e_done = 0; e_err = 0; e_busy = 0;
            m_valid = 1;
        end else begin
            e_done = m_done_flag;
            m_done_flag = 0;
            e_we = 0;
            e_err = 0;
            arr_tag = m_pend_tag;
            m_pend_tag = -1;
            if (!enable) begin
                m_active = 0; m_in_frame = 0; m_pos = 0; m_epoch++;
            end else if (!m_active) begin
                m_active = 1;
            end else if (!m_in_frame) begin
                if (sof) m_in_frame = 1;
            end else begin
                word_ok = (arr_tag == m_epoch);
                if (word_ok && m_pos == N - 1) begin
                    e_we = 1; e_addr = m_pos; e_wdata = expect_pixel(fifo_data);
                    m_done_flag = 1; m_pos = 0; m_in_frame = sof; m_epoch++;
                end else begin
                    if (sof && m_pos != 0) begin
                        e_err = 1; m_pos = 0; m_epoch++;
                    end else if (word_ok) begin
                        e_we = 1; e_addr = m_pos; e_wdata = expect_pixel(fifo_data);
                        m_pos++;
                    end
                    if (rdc) m_pend_tag = m_epoch;
                end
            end
            e_busy = m_in_frame;
        end
    end

    task automatic step(input bit s);
        @(posedge clk);
        #1;
        if (rd_taken && fq.size() > 0) fifo_data = fq.pop_front();
        else fifo_data = 12'($urandom);
        sof = s;
        if (rnd_stall) stall = ($urandom_range(0, 2) == 0);
        else stall = 1'b0;
        fifo_empty = (fq.size() == 0) || stall;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic push_rand(input int n);
        repeat (n) fq.push_back(12'($urandom));
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        while (fq.size() != 0 && k < limit) begin
            step(1'b0);
            k++;
        end
        chk(name, fq.size(), 0);
        run(4);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_we"}, mem_we, 0);
        chk({name, "_addr"}, mem_addr, 0);
        chk({name, "_wdata"}, mem_wdata, 0);
        chk({name, "_done"}, frame_done, 0);
        chk({name, "_err"}, err_short, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_rd"}, fifo_rd, 0);
    endtask

    initial begin
        int b_we, b_done, b_err, k;
        rstn = 1'b0; enable = 1'b0; sof = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

        run(3);
        check_idle_outputs("reset");
        rstn = 1'b1;
        run(2);

        $display("phase pre_sof_flush");
        enable = 1'b1;
        run(2);
        push_rand(20);
        b_we = n_we;
        drain("presof_drain", 100);
        chk("presof_writes", n_we - b_we, 0);

        $display("phase full_frame");
        b_we = n_we; b_done = n_done; b_err = n_err;
        step(1'b1);
        push_rand(N);
        drain("full_drain", N + 50);
        chk("full_writes", n_we - b_we, N);
        chk("full_done", n_done - b_done, 1);
        chk("full_err", n_err - b_err, 0);
        chk("full_last_addr", last_waddr, N - 1);

        $display("phase short_frame");
        wl_addr.delete(); wl_data.delete();
        b_done = n_done; b_err = n_err;
        step(1'b1);
        fq.push_back(12'hF00); fq.push_back(12'hFFF); fq.push_back(12'h0F0);
        push_rand(37);
        drain("short_drain", 200);
        chk("short_wlog_size", wl_addr.size(), 40);
        if (wl_addr.size() >= 3) begin
            chk("short_px0_addr", wl_addr[0], 0);
            chk("short_px0_data", wl_data[0], LIT0);
            chk("short_px1_data", wl_data[1], LIT1);
            chk("short_px2_data", wl_data[2], LIT2);
        end
        step(1'b1);
        run(3);
        chk("short_err", n_err - b_err, 1);
        push_rand(N);
        drain("short_full_drain", N + 50);
        chk("short_done", n_done - b_done, 1);
        chk("short_total_writes", wl_addr.size(), 40 + N);
        if (wl_addr.size() > 40) chk("short_restart_addr", wl_addr[40], 0);

        $display("phase random");
        rnd_stall = 1'b1;
        step(1'b1);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 1) == 0) fq.push_back(12'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                enable = 1'b0;
                run(3);
                enable = 1'b1;
            end
            step($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) step(1'b1);
        end
        rnd_stall = 1'b0;
        drain("random_drain", 3000);

        $display("phase reset_mid_stream");
        step(1'b1);
        push_rand(N);
        k = 0;
        while (!(mem_we === 1'b1 && mem_addr == AW'(100)) && k < 400) begin
            step(1'b0);
            k++;
        end
        chk("reach_addr_100", k < 400, 1);
        rstn = 1'b0;
        step(1'b0);
        check_idle_outputs("midreset");
        rstn = 1'b1;
        fq.delete();
        run(4);
        wl_addr.delete(); wl_data.delete();
        step(1'b1);
        push_rand(5);
        drain("post_reset_drain", 100);
        chk("post_reset_writes", wl_addr.size(), 5);
        if (wl_addr.size() > 0) chk("post_reset_first_addr", wl_addr[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
